// File: rtl/lane_permute_fifo.sv
// Lane-permutation stage: splits a word into lanes, applies a per-beat
// pass/reverse/rotate permutation and queues the result in a small FIFO.
module lane_permute_fifo #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int DEPTH  = 2,
  parameter int AMT_W  = $clog2(LANES)
) (
  input  logic                           CLK,
  input  logic                           ASYNCRESETN,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANE_W*LANES-1:0]        in_data,
  input  logic [1:0]                     in_mode,
  input  logic [AMT_W-1:0]               in_amt,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANE_W*LANES-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int DATA_W = LANE_W * LANES;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_REV  = 2'd1,
    MODE_ROTL = 2'd2,
    MODE_ROTR = 2'd3
  } mode_e;

  // Rotations are done as a right shift of the word concatenated with itself;
  // a rotate-left by a lanes is a rotate-right by LANES-a lanes.
  logic [2*DATA_W-1:0] dbl_word;
  logic [31:0]         amt_mod;
  logic [31:0]         shift_r;
  logic [31:0]         shift_l;
  logic [DATA_W-1:0]   rev_word;
  logic [DATA_W-1:0]   rotl_word;
  logic [DATA_W-1:0]   rotr_word;
  logic [DATA_W-1:0]   perm_word;

  assign dbl_word  = {in_data, in_data};
  assign amt_mod   = 32'(in_amt) % 32'(LANES);
  assign shift_r   = amt_mod * 32'(LANE_W);
  assign shift_l   = (32'(LANES) - amt_mod) * 32'(LANE_W);
  assign rotr_word = DATA_W'(dbl_word >> shift_r);
  assign rotl_word = DATA_W'(dbl_word >> shift_l);

  for (genvar g = 0; g < LANES; g++) begin : g_rev
    assign rev_word[g*LANE_W +: LANE_W] = in_data[(LANES-1-g)*LANE_W +: LANE_W];
  end

  always_comb begin
    perm_word = in_data;
    case (mode_e'(in_mode))
      MODE_PASS: perm_word = in_data;
      MODE_REV:  perm_word = rev_word;
      MODE_ROTL: perm_word = rotl_word;
      MODE_ROTR: perm_word = rotr_word;
      default:   perm_word = in_data;
    endcase
  end

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; valid holds its beat stable until then. in_ready depends on stored
  // occupancy only, so a pop on a full FIFO frees a slot from the next cycle.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              push;
  logic              pop;

  assign in_ready  = (level_q < LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = level_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= perm_word;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_permute_fifo.sv
// Bench for lane_permute_fifo: scoreboarded default instance plus direct-checked
// four-lane and three-lane instances.
module tb_lane_permute_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default instance: LANE_W=8, LANES=2, DEPTH=2
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic [0:0]  in_amt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  level;

  // Four-lane instance
  logic        v4 = 1'b0;
  logic        ir4;
  logic [31:0] d4 = '0;
  logic [1:0]  m4 = '0;
  logic [1:0]  a4 = '0;
  logic        ov4;
  logic [31:0] od4;
  logic [1:0]  lvl4;

  // Three-lane instance
  logic        v3 = 1'b0;
  logic        ir3;
  logic [23:0] d3 = '0;
  logic [1:0]  m3 = '0;
  logic [1:0]  a3 = '0;
  logic        ov3;
  logic [23:0] od3;
  logic [1:0]  lvl3;

  int errors = 0;
  int checks = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [15:0] exp_q[$];

  lane_permute_fifo dut (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  lane_permute_fifo #(.LANE_W(8), .LANES(4), .DEPTH(2)) dut4 (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .in_valid(v4), .in_ready(ir4), .in_data(d4),
    .in_mode(m4), .in_amt(a4),
    .out_valid(ov4), .out_ready(1'b1), .out_data(od4),
    .level(lvl4)
  );

  lane_permute_fifo #(.LANE_W(8), .LANES(3), .DEPTH(2)) dut3 (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .in_valid(v3), .in_ready(ir3), .in_data(d3),
    .in_mode(m3), .in_amt(a3),
    .out_valid(ov3), .out_ready(1'b1), .out_data(od3),
    .level(lvl3)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference permutation: index-based lane selection, LANE_W fixed at 8
  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m,
                                        input int a, input int lanes);
    logic [31:0] r;
    int s;
    int am;
    r = '0;
    am = a % lanes;
    for (int i = 0; i < lanes; i++) begin
      case (m)
        2'd0:    s = i;
        2'd1:    s = lanes - 1 - i;
        2'd2:    s = (i - am + lanes) % lanes;
        default: s = (i + am) % lanes;
      endcase
      r[i*8 +: 8] = d[s*8 +: 8];
    end
    return r;
  endfunction

  // Driver: holds the beat until accepted, records its expected result
  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [0:0] a);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_amt   = a;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      exp_q.push_back(16'(model(32'(d), m, int'(a), 2)));
      n_pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat4(input logic [31:0] d, input logic [1:0] m, input logic [1:0] a);
    v4 = 1'b1; d4 = d; m4 = m; a4 = a;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    check("l4_valid", 32'(ov4), 32'd1);
    check("l4_data", od4, model(d, m, int'(a), 4));
  endtask

  task automatic beat3(input logic [23:0] d, input logic [1:0] m, input logic [1:0] a);
    v3 = 1'b1; d3 = d; m3 = m; a3 = a;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    check("l3_valid", 32'(ov3), 32'd1);
    check("l3_data", 32'(od3), model(32'(d), m, int'(a), 3));
  endtask

  // Scoreboard: a pop happens on the coming edge, compare against queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      n_popped++;
    end
  end

  initial begin
    #3;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and basic modes
    send(16'h1234, 2'd1, 1'b0);
    in_valid = 1'b0;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h3412);
    out_ready = 1'b1;
    send(16'h1234, 2'd0, 1'b0);
    send(16'hbeef, 2'd2, 1'b1);
    send(16'hcafe, 2'd3, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_level", 32'(level), 32'd0);

    // Full and backpressure with a held third beat
    out_ready = 1'b0;
    send(16'h0001, 2'd1, 1'b0);
    send(16'h0002, 2'd1, 1'b0);
    in_data = 16'h0003; in_mode = 2'd1; in_amt = 1'b0;
    check("full_level", 32'(level), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held_in_ready", 32'(in_ready), 32'd0);
    check("held_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_pop_level", 32'(level), 32'd1);
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(16'h0300);
    n_pushed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("push_pop_level", 32'(level), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("full_drain_q", 32'(exp_q.size()), 32'd0);

    // Streaming: one beat per cycle, occupancy pinned at one
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom_range(0, 65535)), 2'(i), 1'($urandom_range(0, 1)));
      check("stream_level", 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);
    check("push_pop_count", 32'(n_popped), 32'(n_pushed));

    // Reset asserted mid-stream with two beats buffered, between edges
    out_ready = 1'b0;
    send(16'haaaa, 2'd0, 1'b0);
    send(16'h5555, 2'd0, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four lanes
    beat4(32'haabbccdd, 2'd2, 2'd1);
    beat4(32'haabbccdd, 2'd3, 2'd1);
    beat4(32'haabbccdd, 2'd1, 2'd0);
    beat4(32'haabbccdd, 2'd2, 2'd0);
    for (int i = 0; i < 6; i++)
      beat4($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Three lanes, rotate amount wraps past LANES
    beat3(24'h112233, 2'd2, 2'd3);
    beat3(24'h112233, 2'd3, 2'd3);
    beat3(24'h112233, 2'd2, 2'd1);
    beat3(24'h112233, 2'd1, 2'd0);
    for (int i = 0; i < 6; i++)
      beat3(24'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
